fp_align_unit: RTL and testbench

Front-end alignment stage of the single-precision FP adder/subtractor. It accepts two IEEE-754 binary32 operands and an add/sub select, and unpacks both operands. It swaps them so the larger magnitude is "big", then right-shifts the smaller mantissa by the exponent difference. Its output is the 28-bit extended mantissa format (hidden + 23 fraction + guard + round + 2 sticky bits) that the downstream add, normalize and rounding stages consume. It is a 2-stage valid/ready pipeline.

---
 rtl/fp_align_unit_if.sv | 31 +++
 rtl/fp_align_unit.sv | 150 +++++++++++++++
 tb/tb_fp_align_unit.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_align_unit_if.sv
// Handshake and data bundle of the FP adder alignment stage.
// The design uses the slave modport and the driving side uses the master modport.
interface fp_align_unit_if #(
  parameter int SIZE_EXP = 8,
  parameter int SIZE_MAN = 28
);
  logic                i_valid;
  logic                o_ready;
  logic [31:0]         i_data_a;
  logic [31:0]         i_data_b;
  logic                i_sub;
  logic                o_valid;
  logic                i_ready;
  logic                o_sign;
  logic                o_eff_sub;
  logic [SIZE_EXP-1:0] o_exp;
  logic [SIZE_MAN-1:0] o_man_big;
  logic [SIZE_MAN-1:0] o_man_small;
  logic                o_nan;
  logic                o_inf;

  modport slave (
    input  i_valid, i_data_a, i_data_b, i_sub, i_ready,
    output o_ready, o_valid, o_sign, o_eff_sub, o_exp, o_man_big, o_man_small, o_nan, o_inf
  );

  modport master (
    output i_valid, i_data_a, i_data_b, i_sub, i_ready,
    input  o_ready, o_valid, o_sign, o_eff_sub, o_exp, o_man_big, o_man_small, o_nan, o_inf
  );
endinterface

// File: rtl/fp_align_unit.sv
// Two-stage compare/swap and align front end of the binary32 adder.
// Macro FP_ALIGN_DENORM_EN keeps denormal operands; undefined, exp-0 operands flush to +0.
module fp_align_unit #(
  parameter int SIZE_EXP  = 8,
  parameter int SIZE_FRAC = 23,
  parameter int SIZE_MAN  = 28
) (
  input  logic           i_clk,
  input  logic           i_rst,
  fp_align_unit_if.slave io_bus
);
  localparam int SIZE_M   = SIZE_FRAC + 1;
  localparam int SIZE_W   = SIZE_EXP + SIZE_FRAC + 1;
  localparam int SIZE_EXT = SIZE_MAN - SIZE_M;
  localparam int SH_W     = $clog2(SIZE_MAN);
  localparam logic [SIZE_EXP-1:0] EXP_MAX   = '1;
  localparam logic [SIZE_EXP-1:0] EXP_ONE   = SIZE_EXP'(1);
  localparam logic [SIZE_EXP-1:0] SHIFT_LIM = SIZE_EXP'(SIZE_MAN);

  logic                r_s1Valid;
  logic [SIZE_M-1:0]   r_s1ManBig;
  logic [SIZE_M-1:0]   r_s1ManSmall;
  logic [SIZE_EXP-1:0] r_s1Exp;
  logic [SIZE_EXP-1:0] r_s1Shift;
  logic                r_s1Sign;
  logic                r_s1EffSub;
  logic                r_s1Nan;
  logic                r_s1Inf;

  logic                r_oValid;
  logic [SIZE_MAN-1:0] r_oManBig;
  logic [SIZE_MAN-1:0] r_oManSmall;
  logic [SIZE_EXP-1:0] r_oExp;
  logic                r_oSign;
  logic                r_oEffSub;
  logic                r_oNan;
  logic                r_oInf;

  logic                w_en;
  logic [SIZE_EXP-1:0] w_expA, w_expB, w_eexpA, w_eexpB;
  logic [SIZE_FRAC-1:0] w_fracA, w_fracB;
  logic [SIZE_M-1:0]   w_manA, w_manB;
  logic                w_nanA, w_nanB, w_infA, w_infB;
  logic                w_signA, w_signB, w_effSub, w_aBig, w_nan, w_inf;
  logic [SIZE_EXP-1:0] w_shift;
  logic [SIZE_MAN-1:0] w_ext, w_mask, w_aligned;
  logic [SH_W-1:0]     w_sh;
  logic                w_far;

  // Whole pipeline advances together; a held result freezes both stages.
  assign w_en           = !r_oValid || io_bus.i_ready;
  assign io_bus.o_ready = w_en;

  assign w_expA  = io_bus.i_data_a[SIZE_W-2 -: SIZE_EXP];
  assign w_expB  = io_bus.i_data_b[SIZE_W-2 -: SIZE_EXP];
  assign w_fracA = io_bus.i_data_a[SIZE_FRAC-1:0];
  assign w_fracB = io_bus.i_data_b[SIZE_FRAC-1:0];
  assign w_nanA  = (w_expA == EXP_MAX) && (w_fracA != '0);
  assign w_nanB  = (w_expB == EXP_MAX) && (w_fracB != '0);
  assign w_infA  = (w_expA == EXP_MAX) && (w_fracA == '0);
  assign w_infB  = (w_expB == EXP_MAX) && (w_fracB == '0);

`ifdef FP_ALIGN_DENORM_EN
  assign w_manA  = {w_expA != '0, w_fracA};
  assign w_manB  = {w_expB != '0, w_fracB};
  assign w_eexpA = (w_expA == '0) ? EXP_ONE : w_expA;
  assign w_eexpB = (w_expB == '0) ? EXP_ONE : w_expB;
`else
  assign w_manA  = (w_expA == '0) ? '0 : {1'b1, w_fracA};
  assign w_manB  = (w_expB == '0) ? '0 : {1'b1, w_fracB};
  assign w_eexpA = w_expA;
  assign w_eexpB = w_expB;
`endif

  // B's sign is flipped for subtraction so the rest of the datapath only adds.
  assign w_signA  = io_bus.i_data_a[SIZE_W-1];
  assign w_signB  = io_bus.i_data_b[SIZE_W-1] ^ io_bus.i_sub;
  assign w_effSub = w_signA ^ w_signB;
  assign w_aBig   = (w_eexpA > w_eexpB) || ((w_eexpA == w_eexpB) && (w_manA >= w_manB));
  assign w_shift  = w_aBig ? (w_eexpA - w_eexpB) : (w_eexpB - w_eexpA);
  assign w_nan    = w_nanA || w_nanB || (w_infA && w_infB && w_effSub);
  assign w_inf    = (w_infA || w_infB) && !w_nan;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1Valid    <= 1'b0;
      r_s1ManBig   <= '0;
      r_s1ManSmall <= '0;
      r_s1Exp      <= '0;
      r_s1Shift    <= '0;
      r_s1Sign     <= 1'b0;
      r_s1EffSub   <= 1'b0;
      r_s1Nan      <= 1'b0;
      r_s1Inf      <= 1'b0;
    end else if (w_en) begin
      r_s1Valid <= io_bus.i_valid;
      if (io_bus.i_valid) begin
        r_s1ManBig   <= w_aBig ? w_manA : w_manB;
        r_s1ManSmall <= w_aBig ? w_manB : w_manA;
        r_s1Exp      <= w_aBig ? w_eexpA : w_eexpB;
        r_s1Shift    <= w_shift;
        r_s1Sign     <= w_aBig ? w_signA : w_signB;
        r_s1EffSub   <= w_effSub;
        r_s1Nan      <= w_nan;
        r_s1Inf      <= w_inf;
      end
    end
  end

  // Bits shifted out below bit 0 collapse into a sticky OR on bit 0.
  assign w_ext   = {r_s1ManSmall, {SIZE_EXT{1'b0}}};
  assign w_far   = (r_s1Shift >= SHIFT_LIM);
  assign w_sh    = r_s1Shift[SH_W-1:0];
  assign w_mask  = (SIZE_MAN'(1) << w_sh) - SIZE_MAN'(1);
  assign w_aligned = w_far ? {{(SIZE_MAN-1){1'b0}}, (r_s1ManSmall != '0)}
                           : ((w_ext >> w_sh) | {{(SIZE_MAN-1){1'b0}}, ((w_ext & w_mask) != '0)});

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_oValid    <= 1'b0;
      r_oManBig   <= '0;
      r_oManSmall <= '0;
      r_oExp      <= '0;
      r_oSign     <= 1'b0;
      r_oEffSub   <= 1'b0;
      r_oNan      <= 1'b0;
      r_oInf      <= 1'b0;
    end else if (w_en) begin
      r_oValid <= r_s1Valid;
      if (r_s1Valid) begin
        r_oManBig   <= {r_s1ManBig, {SIZE_EXT{1'b0}}};
        r_oManSmall <= w_aligned;
        r_oExp      <= r_s1Exp;
        r_oSign     <= r_s1Sign;
        r_oEffSub   <= r_s1EffSub;
        r_oNan      <= r_s1Nan;
        r_oInf      <= r_s1Inf;
      end
    end
  end

  assign io_bus.o_valid     = r_oValid;
  assign io_bus.o_man_big   = r_oManBig;
  assign io_bus.o_man_small = r_oManSmall;
  assign io_bus.o_exp       = r_oExp;
  assign io_bus.o_sign      = r_oSign;
  assign io_bus.o_eff_sub   = r_oEffSub;
  assign io_bus.o_nan       = r_oNan;
  assign io_bus.o_inf       = r_oInf;
endmodule

// File: tb/tb_fp_align_unit.sv
// Bench for fp_align_unit: directed vector table, backpressure/reset sequences,
// and random traffic scored against an arithmetic model of the alignment rules.
module tb_fp_align_unit;
  typedef struct {
    logic [7:0]  exp;
    logic [27:0] manBig;
    logic [27:0] manSmall;
    logic        sign;
    logic        effSub;
    logic        nan;
    logic        inf;
  } result_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    result_t     res;
  } vector_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fp_align_unit_if bus();
  fp_align_unit dut (.i_clk(clk), .i_rst(rst), .io_bus(bus));

  result_t expQ[$];
  result_t curExp;
  int checks = 0;
  int errors = 0;

  function automatic result_t mkRes(logic [7:0] e, logic [27:0] mb, logic [27:0] ms,
                                    logic s, logic es, logic n, logic i);
    result_t r;
    r.exp = e; r.manBig = mb; r.manSmall = ms;
    r.sign = s; r.effSub = es; r.nan = n; r.inf = i;
    return r;
  endfunction

  function automatic vector_t mkVec(logic [31:0] a, logic [31:0] b, logic sub, result_t r);
    vector_t v;
    v.a = a; v.b = b; v.sub = sub; v.res = r;
    return v;
  endfunction

  // Reference: unpack by the IEEE rules, pick the larger magnitude, divide by 2^d with sticky.
  function automatic result_t model(logic [31:0] a, logic [31:0] b, logic sub);
    result_t r;
    int ea, eb, xa, xb, d;
    longint ma, mb, mBig, mSmall, ext, den, val;
    bit aBig, nanA, nanB, infA, infB, sa, sb;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    nanA = (ea == 255) && (a[22:0] != 0);
    nanB = (eb == 255) && (b[22:0] != 0);
    infA = (ea == 255) && (a[22:0] == 0);
    infB = (eb == 255) && (b[22:0] == 0);
`ifdef FP_ALIGN_DENORM_EN
    ma = (ea != 0 ? 64'h800000 : 64'h0) + longint'(a[22:0]);
    mb = (eb != 0 ? 64'h800000 : 64'h0) + longint'(b[22:0]);
    xa = (ea == 0) ? 1 : ea;
    xb = (eb == 0) ? 1 : eb;
`else
    ma = (ea == 0) ? 64'h0 : 64'h800000 + longint'(a[22:0]);
    mb = (eb == 0) ? 64'h0 : 64'h800000 + longint'(b[22:0]);
    xa = ea;
    xb = eb;
`endif
    sa = a[31];
    sb = b[31] ^ sub;
    aBig = (xa > xb) || ((xa == xb) && (ma >= mb));
    d = aBig ? xa - xb : xb - xa;
    mBig = aBig ? ma : mb;
    mSmall = aBig ? mb : ma;
    ext = mSmall * 16;
    if (d >= 28) begin
      val = (mSmall != 0) ? 1 : 0;
    end else begin
      den = longint'(1) << d;
      val = ext / den;
      if ((ext % den) != 0) val = val | 1;
    end
    r.exp = 8'(aBig ? xa : xb);
    r.manBig = 28'(mBig * 16);
    r.manSmall = 28'(val);
    r.sign = aBig ? sa : sb;
    r.effSub = sa ^ sb;
    r.nan = nanA || nanB || (infA && infB && r.effSub);
    r.inf = (infA || infB) && !r.nan;
    return r;
  endfunction

  task automatic checkVal(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic checkOutput(result_t e, string tag);
    checkVal({tag, ".exp"}, bus.o_exp, e.exp);
    checkVal({tag, ".manBig"}, bus.o_man_big, e.manBig);
    checkVal({tag, ".manSmall"}, bus.o_man_small, e.manSmall);
    checkVal({tag, ".sign"}, bus.o_sign, e.sign);
    checkVal({tag, ".effSub"}, bus.o_eff_sub, e.effSub);
    checkVal({tag, ".nan"}, bus.o_nan, e.nan);
    checkVal({tag, ".inf"}, bus.o_inf, e.inf);
  endtask

  // One clock: score the visible output against the queue head, record an accept, advance.
  task automatic stepCycle(output bit acc);
    #1;
    acc = bus.i_valid && bus.o_ready;
    checkVal("readyRule", bus.o_ready, !bus.o_valid || bus.i_ready);
    if (bus.o_valid) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL spurious o_valid actual=1 expected=0");
      end else begin
        checkOutput(expQ[0], "out");
        if (bus.i_ready) void'(expQ.pop_front());
      end
    end
    if (acc) expQ.push_back(curExp);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic applyStimulus(logic [31:0] a, logic [31:0] b, logic sub, result_t e,
                               output int tries);
    bit acc;
    bus.i_data_a = a;
    bus.i_data_b = b;
    bus.i_sub = sub;
    bus.i_valid = 1'b1;
    curExp = e;
    tries = 0;
    acc = 1'b0;
    while (!acc && tries < 20) begin
      stepCycle(acc);
      tries++;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept timeout actual=0 expected=1");
    end
    bus.i_valid = 1'b0;
  endtask

  task automatic drain();
    bit acc;
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    for (int i = 0; i < 20 && expQ.size() != 0; i++) stepCycle(acc);
    checkVal("drainQueue", expQ.size(), 0);
  endtask

  task automatic checkResetState(string tag);
    checkVal({tag, ".valid"}, bus.o_valid, 0);
    checkVal({tag, ".ready"}, bus.o_ready, 1);
    checkOutput(mkRes(8'h0, 28'h0, 28'h0, 1'b0, 1'b0, 1'b0, 1'b0), tag);
  endtask

  function automatic logic [31:0] randOperand(logic [7:0] nearExp, bit useNear);
    int sel, e;
    sel = $urandom_range(0, 9);
    if (sel == 0) e = 0;
    else if (sel == 1) e = 255;
    else if (useNear) begin
      e = int'(nearExp) + $urandom_range(0, 40) - 20;
      if (e < 1) e = 1;
      if (e > 254) e = 254;
    end else e = $urandom_range(0, 255);
    return {1'($urandom_range(0, 1)), 8'(e), 23'($urandom)};
  endfunction

  vector_t vecs[14];
  logic [27:0] denSmall;
  logic [7:0]  zeroExp;

  initial begin
    bit acc;
    int tries;
    logic [31:0] ra, rb;
    logic rsub;
    bit pending;

`ifdef FP_ALIGN_DENORM_EN
    denSmall = 28'h1;
    zeroExp = 8'h1;
`else
    denSmall = 28'h0;
    zeroExp = 8'h0;
`endif
    vecs[0]  = mkVec(32'h3F800000, 32'h3F800000, 1'b0, mkRes(8'h7F, 28'h8000000, 28'h8000000, 0, 0, 0, 0));
    vecs[1]  = mkVec(32'h3E000000, 32'h3F800000, 1'b1, mkRes(8'h7F, 28'h8000000, 28'h1000000, 1, 1, 0, 0));
    vecs[2]  = mkVec(32'h3F800000, 32'h30800001, 1'b0, mkRes(8'h7F, 28'h8000000, 28'h0000001, 0, 0, 0, 0));
    vecs[3]  = mkVec(32'h3F800000, 32'h3FC00000, 1'b1, mkRes(8'h7F, 28'hC000000, 28'h8000000, 1, 1, 0, 0));
    vecs[4]  = mkVec(32'h3F800000, 32'h00000001, 1'b0, mkRes(8'h7F, 28'h8000000, denSmall, 0, 0, 0, 0));
    vecs[5]  = mkVec(32'h7F800000, 32'hFF800000, 1'b0, mkRes(8'hFF, 28'h8000000, 28'h8000000, 0, 1, 1, 0));
    vecs[6]  = mkVec(32'h7F800000, 32'h3F800000, 1'b0, mkRes(8'hFF, 28'h8000000, 28'h0000001, 0, 0, 0, 1));
    vecs[7]  = mkVec(32'h7FC00000, 32'h3F800000, 1'b0, mkRes(8'hFF, 28'hC000000, 28'h0000001, 0, 0, 1, 0));
    vecs[8]  = mkVec(32'h00000000, 32'h80000000, 1'b1, mkRes(zeroExp, 28'h0, 28'h0, 0, 0, 0, 0));
    vecs[9]  = mkVec(32'h3F800000, 32'h33C00000, 1'b0, mkRes(8'h7F, 28'h8000000, 28'h000000C, 0, 0, 0, 0));
    vecs[10] = mkVec(32'h3F800000, 32'h33C00001, 1'b0, mkRes(8'h7F, 28'h8000000, 28'h000000D, 0, 0, 0, 0));
    vecs[11] = mkVec(32'hBF800000, 32'h3F800000, 1'b0, mkRes(8'h7F, 28'h8000000, 28'h8000000, 1, 1, 0, 0));
    vecs[12] = mkVec(32'h3F800000, 32'h32400000, 1'b0, mkRes(8'h7F, 28'h8000000, 28'h0000001, 0, 0, 0, 0));
    vecs[13] = mkVec(32'h7F800000, 32'h7F800000, 1'b1, mkRes(8'hFF, 28'h8000000, 28'h8000000, 0, 1, 1, 0));

    rst = 1'b1;
    bus.i_valid = 1'b0;
    bus.i_data_a = '0;
    bus.i_data_b = '0;
    bus.i_sub = 1'b0;
    bus.i_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checkResetState("reset");
    rst = 1'b0;

    // Directed table; the first vector lands on the reset-release cycle.
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].res, tries);
      checkVal($sformatf("vec%0d.tries", i), tries, 1);
      #1 checkVal($sformatf("vec%0d.lat1", i), bus.o_valid, 0);
      stepCycle(acc);
      #1 checkVal($sformatf("vec%0d.lat2", i), bus.o_valid, 1);
      drain();
    end

    // Backpressure: fill with ready low, hold, then release and drain in order.
    bus.i_ready = 1'b0;
    applyStimulus(32'h40400000, 32'h3F800000, 1'b0, model(32'h40400000, 32'h3F800000, 1'b0), tries);
    applyStimulus(32'h41200000, 32'hC0000000, 1'b1, model(32'h41200000, 32'hC0000000, 1'b1), tries);
    bus.i_data_a = 32'h3E800000;
    bus.i_data_b = 32'h42C80000;
    bus.i_sub = 1'b1;
    bus.i_valid = 1'b1;
    curExp = model(32'h3E800000, 32'h42C80000, 1'b1);
    for (int k = 0; k < 3; k++) begin
      #1 checkVal("bpReady", bus.o_ready, 0);
      stepCycle(acc);
      checkVal("bpNoAccept", acc, 0);
    end
    checkVal("bpQueueDepth", expQ.size(), 2);
    bus.i_ready = 1'b1;
    applyStimulus(32'h3E800000, 32'h42C80000, 1'b1, curExp, tries);
    drain();

    // Reset mid-stream discards work in flight.
    bus.i_ready = 1'b0;
    applyStimulus(32'h40400000, 32'h3F800000, 1'b0, model(32'h40400000, 32'h3F800000, 1'b0), tries);
    applyStimulus(32'h41200000, 32'hC0000000, 1'b1, model(32'h41200000, 32'hC0000000, 1'b1), tries);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    checkResetState("midReset");
    expQ.delete();
    rst = 1'b0;
    bus.i_ready = 1'b1;
    applyStimulus(32'h3F800000, 32'h3E000000, 1'b0, model(32'h3F800000, 32'h3E000000, 1'b0), tries);
    checkVal("releaseAcceptTries", tries, 1);
    drain();

    // Random traffic with random backpressure.
    pending = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      if (!pending && $urandom_range(0, 3) != 0) begin
        ra = randOperand(8'h7F, 1'b0);
        rb = randOperand(ra[30:23], $urandom_range(0, 1) == 1);
        rsub = 1'($urandom_range(0, 1));
        bus.i_data_a = ra;
        bus.i_data_b = rb;
        bus.i_sub = rsub;
        curExp = model(ra, rb, rsub);
        bus.i_valid = 1'b1;
        pending = 1'b1;
      end
      bus.i_ready = ($urandom_range(0, 3) != 0);
      stepCycle(acc);
      if (acc) begin
        pending = 1'b0;
        bus.i_valid = 1'b0;
      end
    end
    bus.i_valid = 1'b0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
